renkon_linebuf: RTL and testbench

Window generator at the input side of the renkon processing core. Accepts a raster-ordered stream of feature-map pixels, one per accepted cycle. Stores the last four rows in internal line buffers and presents every complete 5x5 window as 25 parallel pixels. These pixels drive `pixel0`..`pixel24` of the conv/bias/relu/pool pipeline. Together with the image-memory reader, it is the producer the core's pixel inputs expect.

---
 rtl/renkon_linebuf.sv | 185 ++++++++++++++++++
 tb/tb_renkon_linebuf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_linebuf.sv
// renkon_linebuf
// Window generator at the input side of the renkon core. It takes a
// raster-ordered pixel stream, keeps the last four rows in line buffers and
// presents every complete 5x5 window as 25 parallel registered pixels.
//
// Ports
//   clk          clock, rising edge
//   xrst         synchronous reset, active high
//   buf_start    one-cycle pulse: start a new feature map (aborts a running one)
//   img_size     map edge W, sampled on buf_start; legal range FSIZE..MAXW
//   pixel_in     incoming pixel, raster order
//   in_valid     pixel_in valid; accepted only in RUN
//   pixel0..24   window, pixel(5r+c) = row r, col c; row/col 0 = oldest
//   win_valid    window outputs carry a new complete window this cycle
//   frame_done   pulse with the final window of a map
//   size_err     sticky: last buf_start carried an illegal img_size
//
// State   | Meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for buf_start; in_valid ignored
// S_RUN   | accepting pixels, producing windows until (W-1, W-1)
module renkon_linebuf #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int FSIZE  = 5,
  parameter int MAXW   = 256
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     buf_start,
  input  logic        [LWIDTH-1:0] img_size,
  input  logic signed [DWIDTH-1:0] pixel_in,
  input  logic                     in_valid,
  output logic signed [DWIDTH-1:0] pixel0,
  output logic signed [DWIDTH-1:0] pixel1,
  output logic signed [DWIDTH-1:0] pixel2,
  output logic signed [DWIDTH-1:0] pixel3,
  output logic signed [DWIDTH-1:0] pixel4,
  output logic signed [DWIDTH-1:0] pixel5,
  output logic signed [DWIDTH-1:0] pixel6,
  output logic signed [DWIDTH-1:0] pixel7,
  output logic signed [DWIDTH-1:0] pixel8,
  output logic signed [DWIDTH-1:0] pixel9,
  output logic signed [DWIDTH-1:0] pixel10,
  output logic signed [DWIDTH-1:0] pixel11,
  output logic signed [DWIDTH-1:0] pixel12,
  output logic signed [DWIDTH-1:0] pixel13,
  output logic signed [DWIDTH-1:0] pixel14,
  output logic signed [DWIDTH-1:0] pixel15,
  output logic signed [DWIDTH-1:0] pixel16,
  output logic signed [DWIDTH-1:0] pixel17,
  output logic signed [DWIDTH-1:0] pixel18,
  output logic signed [DWIDTH-1:0] pixel19,
  output logic signed [DWIDTH-1:0] pixel20,
  output logic signed [DWIDTH-1:0] pixel21,
  output logic signed [DWIDTH-1:0] pixel22,
  output logic signed [DWIDTH-1:0] pixel23,
  output logic signed [DWIDTH-1:0] pixel24,
  output logic                     win_valid,
  output logic                     frame_done,
  output logic                     size_err
);

  localparam int AW   = $clog2(MAXW);
  localparam int NROW = FSIZE - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]              r_state;
  logic [LWIDTH-1:0]       r_width;
  logic [LWIDTH-1:0]       r_row;
  logic [LWIDTH-1:0]       r_col;
  logic signed [DWIDTH-1:0] r_lb  [NROW][MAXW];
  logic signed [DWIDTH-1:0] r_win [FSIZE*FSIZE];
  logic                    r_win_valid;
  logic                    r_frame_done;
  logic                    r_size_err;

  logic                    w_accept;
  logic                    w_size_ok;
  logic                    w_last_col;
  logic                    w_last_row;
  logic [AW-1:0]           w_addr;
  logic signed [DWIDTH-1:0] w_slice [FSIZE];

  assign w_addr     = r_col[AW-1:0];
  assign w_size_ok  = (img_size >= LWIDTH'(FSIZE)) && (img_size <= LWIDTH'(MAXW));
  // A start in the same cycle wins over the pixel, which is dropped.
  assign w_accept   = (r_state == S_RUN) && in_valid && !buf_start;
  assign w_last_col = (r_col == r_width - LWIDTH'(1));
  assign w_last_row = (r_row == r_width - LWIDTH'(1));

  // Vertical slice: line buffer 0 holds row-4, buffer NROW-1 holds row-1.
  always_comb begin
    for (int i = 0; i < NROW; i++) w_slice[i] = r_lb[i][w_addr];
    w_slice[NROW] = pixel_in;
  end

  // Each row buffer reads and then overwrites the same column address, so
  // every buffer ages by one row per accepted pixel. Contents are never reset.
  always_ff @(posedge clk) begin
    if (!xrst && w_accept) begin
      for (int i = 0; i < NROW - 1; i++) r_lb[i][w_addr] <= r_lb[i+1][w_addr];
      r_lb[NROW-1][w_addr] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_size_err   <= 1'b0;
      for (int k = 0; k < FSIZE*FSIZE; k++) r_win[k] <= '0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (buf_start) begin
        r_row <= '0;
        r_col <= '0;
        if (w_size_ok) begin
          r_width    <= img_size;
          r_state    <= S_RUN;
          r_size_err <= 1'b0;
        end else begin
          r_state    <= S_IDLE;
          r_size_err <= 1'b1;
        end
      end else if (w_accept) begin
        r_win_valid <= (r_row >= LWIDTH'(NROW)) && (r_col >= LWIDTH'(NROW));
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row        <= '0;
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_row <= r_row + LWIDTH'(1);
          end
        end else begin
          r_col <= r_col + LWIDTH'(1);
        end
        for (int r = 0; r < FSIZE; r++) begin
          for (int c = 0; c < FSIZE - 1; c++) r_win[r*FSIZE+c] <= r_win[r*FSIZE+c+1];
          r_win[r*FSIZE+FSIZE-1] <= w_slice[r];
        end
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
  assign size_err   = r_size_err;

  assign pixel0  = r_win[0];
  assign pixel1  = r_win[1];
  assign pixel2  = r_win[2];
  assign pixel3  = r_win[3];
  assign pixel4  = r_win[4];
  assign pixel5  = r_win[5];
  assign pixel6  = r_win[6];
  assign pixel7  = r_win[7];
  assign pixel8  = r_win[8];
  assign pixel9  = r_win[9];
  assign pixel10 = r_win[10];
  assign pixel11 = r_win[11];
  assign pixel12 = r_win[12];
  assign pixel13 = r_win[13];
  assign pixel14 = r_win[14];
  assign pixel15 = r_win[15];
  assign pixel16 = r_win[16];
  assign pixel17 = r_win[17];
  assign pixel18 = r_win[18];
  assign pixel19 = r_win[19];
  assign pixel20 = r_win[20];
  assign pixel21 = r_win[21];
  assign pixel22 = r_win[22];
  assign pixel23 = r_win[23];
  assign pixel24 = r_win[24];

endmodule

// File: tb/tb_renkon_linebuf.sv
// Bench for renkon_linebuf. Pixel values are offset + raster index, so the
// expected window for an accepted pixel at (row, col) is computed directly
// and queued; the monitor pops one entry per win_valid cycle.
module tb_renkon_linebuf;
  localparam int DW = 16;
  localparam int LW = 10;

  typedef struct packed {
    logic              fd;
    logic [24:0][DW-1:0] p;
  } win_t;

  logic                 clk = 1'b0;
  logic                 xrst = 1'b1;
  logic                 buf_start = 1'b0;
  logic                 in_valid = 1'b0;
  logic [LW-1:0]        img_size = '0;
  logic signed [DW-1:0] pixel_in = '0;
  logic signed [DW-1:0] px [25];
  logic                 win_valid, frame_done, size_err;
  logic [24:0][DW-1:0]  obs;

  win_t exp_q[$];
  win_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   win_seen = 0;
  int   fd_seen = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 25; k++) obs[k] = px[k];
  end

  renkon_linebuf dut (
    .clk(clk), .xrst(xrst), .buf_start(buf_start), .img_size(img_size),
    .pixel_in(pixel_in), .in_valid(in_valid),
    .pixel0(px[0]),   .pixel1(px[1]),   .pixel2(px[2]),   .pixel3(px[3]),   .pixel4(px[4]),
    .pixel5(px[5]),   .pixel6(px[6]),   .pixel7(px[7]),   .pixel8(px[8]),   .pixel9(px[9]),
    .pixel10(px[10]), .pixel11(px[11]), .pixel12(px[12]), .pixel13(px[13]), .pixel14(px[14]),
    .pixel15(px[15]), .pixel16(px[16]), .pixel17(px[17]), .pixel18(px[18]), .pixel19(px[19]),
    .pixel20(px[20]), .pixel21(px[21]), .pixel22(px[22]), .pixel23(px[23]), .pixel24(px[24]),
    .win_valid(win_valid), .frame_done(frame_done), .size_err(size_err)
  );

  // Scoreboard pop side, sampled away from the rising edge.
  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      win_seen++;
      if (frame_done === 1'b1) fd_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window got pixel0=%0d pixel24=%0d required no window",
                 obs[0], obs[24]);
      end else begin
        mon_e = exp_q.pop_front();
        if ({frame_done, obs} !== mon_e) begin
          bad++;
          $display("FAIL window got pixel0=%0d pixel12=%0d pixel24=%0d fd=%0b required pixel0=%0d pixel12=%0d pixel24=%0d fd=%0b",
                   obs[0], obs[12], obs[24], frame_done,
                   mon_e.p[0], mon_e.p[12], mon_e.p[24], mon_e.fd);
        end
      end
    end else if (frame_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL frame_done_alone got frame_done=1 win_valid=%0b required frame_done only with window",
               win_valid);
    end
  end

  task automatic start_map(input int w, input logic junk_valid);
    buf_start = 1'b1;
    img_size  = LW'(w);
    in_valid  = junk_valid;
    pixel_in  = DW'($urandom);
    @(posedge clk); #1;
    buf_start = 1'b0;
    in_valid  = 1'b0;
  endtask

  // Drives raster pixels k0..k1-1 of a WxW map; pct = in_valid probability.
  task automatic feed(input int w, input int k0, input int k1, input int pct, input int off);
    int   row, col, tries;
    win_t e;
    for (int k = k0; k < k1; k++) begin
      row = k / w;
      col = k % w;
      tries = 0;
      do begin
        in_valid = ($urandom_range(99) < pct);
        pixel_in = in_valid ? DW'(off + k) : DW'($urandom);
        if (in_valid && row >= 4 && col >= 4) begin
          e.fd = (row == w - 1) && (col == w - 1);
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              e.p[5*i+j] = DW'(off + (row - 4 + i) * w + (col - 4 + j));
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        tries++;
      end while (!in_valid && tries < 1000);
      if (!in_valid) begin
        total++;
        bad++;
        $display("FAIL feed_timeout got no accept after %0d cycles required accept", tries);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    xrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_pixels got pixel0=%0d pixel24=%0d required 0", obs[0], obs[24]); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid got %0b required 0", win_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got %0b required 0", frame_done); end
    total++; if (size_err !== 1'b0) begin bad++; $display("FAIL reset_size_err got %0b required 0", size_err); end
    xrst = 1'b0;
    start_map(3, 1'b0);
    total++; if (size_err !== 1'b1) begin bad++; $display("FAIL size3_err got %0b required 1", size_err); end
    xrst = 1'b1;
    @(posedge clk); #1;
    total++; if (size_err !== 1'b0) begin bad++; $display("FAIL reset_clears_err got %0b required 0", size_err); end
    xrst = 1'b0;
  endtask

  task automatic test_w5;
    int wb = win_seen, fb = fd_seen;
    start_map(5, 1'b0);
    total++; if (size_err !== 1'b0) begin bad++; $display("FAIL w5_size_err got %0b required 0", size_err); end
    feed(5, 0, 25, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL w5_pending got %0d required 0", exp_q.size()); end
    total++; if (win_seen - wb != 1) begin bad++; $display("FAIL w5_windows got %0d required 1", win_seen - wb); end
    total++; if (fd_seen - fb != 1) begin bad++; $display("FAIL w5_frame_done got %0d required 1", fd_seen - fb); end
  endtask

  task automatic test_w8_cont;
    int wb = win_seen, fb = fd_seen;
    start_map(8, 1'b0);
    feed(8, 0, 64, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL w8_pending got %0d required 0", exp_q.size()); end
    total++; if (win_seen - wb != 16) begin bad++; $display("FAIL w8_windows got %0d required 16", win_seen - wb); end
    total++; if (fd_seen - fb != 1) begin bad++; $display("FAIL w8_frame_done got %0d required 1", fd_seen - fb); end
    // back in IDLE: pixels must be ignored
    wb = win_seen;
    in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (win_seen != wb) begin bad++; $display("FAIL idle_ignores got %0d windows required 0", win_seen - wb); end
  endtask

  task automatic test_w8_random;
    int wb = win_seen;
    // start coincident with a valid pixel: the pixel is dropped
    start_map(8, 1'b1);
    feed(8, 0, 64, 50, 0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_pending got %0d required 0", exp_q.size()); end
    total++; if (win_seen - wb != 16) begin bad++; $display("FAIL rnd_windows got %0d required 16", win_seen - wb); end
    total++; if (obs[0] !== DW'(27) || obs[24] !== DW'(63)) begin
      bad++; $display("FAIL rnd_hold got pixel0=%0d pixel24=%0d required 27 63", obs[0], obs[24]);
    end
  endtask

  task automatic test_bad_size;
    int wb = win_seen;
    start_map(4, 1'b0);
    total++; if (size_err !== 1'b1) begin bad++; $display("FAIL size4_err got %0b required 1", size_err); end
    in_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (win_seen != wb) begin bad++; $display("FAIL size4_no_window got %0d required 0", win_seen - wb); end
    start_map(257, 1'b0);
    total++; if (size_err !== 1'b1) begin bad++; $display("FAIL size257_err got %0b required 1", size_err); end
    start_map(6, 1'b0);
    total++; if (size_err !== 1'b0) begin bad++; $display("FAIL size6_err got %0b required 0", size_err); end
    feed(6, 0, 36, 100, 100);
    repeat (3) @(posedge clk);
    #1;
    total++; if (win_seen - wb != 4) begin bad++; $display("FAIL size6_windows got %0d required 4", win_seen - wb); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL size6_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_abort;
    int wb = win_seen, fb = fd_seen;
    start_map(8, 1'b0);
    feed(8, 0, 20, 100, 0);
    start_map(8, 1'b1);
    feed(8, 0, 36, 100, 1000);
    repeat (2) @(posedge clk);
    #1;
    total++; if (win_seen != wb) begin bad++; $display("FAIL abort_early got %0d windows required 0", win_seen - wb); end
    feed(8, 36, 37, 100, 1000);
    @(negedge clk); #1;
    total++; if (win_seen - wb != 1) begin bad++; $display("FAIL abort_first got %0d windows required 1", win_seen - wb); end
    feed(8, 37, 64, 100, 1000);
    repeat (3) @(posedge clk);
    #1;
    total++; if (win_seen - wb != 16) begin bad++; $display("FAIL abort_windows got %0d required 16", win_seen - wb); end
    total++; if (fd_seen - fb != 1) begin bad++; $display("FAIL abort_frame_done got %0d required 1", fd_seen - fb); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_xrst;
    int wb = win_seen;
    start_map(8, 1'b0);
    feed(8, 0, 40, 100, 0);
    @(negedge clk); #1;
    total++; if (win_seen - wb != 4) begin bad++; $display("FAIL xrst_pre got %0d windows required 4", win_seen - wb); end
    xrst = 1'b1;
    in_valid = 1'b1;
    pixel_in = DW'(40);
    @(posedge clk); #1;
    xrst = 1'b0;
    total++; if (obs !== '0) begin bad++; $display("FAIL xrst_pixels got pixel0=%0d pixel24=%0d required 0", obs[0], obs[24]); end
    total++; if (win_valid !== 1'b0 || frame_done !== 1'b0 || size_err !== 1'b0) begin
      bad++; $display("FAIL xrst_flags got wv=%0b fd=%0b err=%0b required 0 0 0", win_valid, frame_done, size_err);
    end
    wb = win_seen;
    repeat (30) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (win_seen != wb || obs !== '0) begin
      bad++; $display("FAIL xrst_idle got %0d windows pixel24=%0d required 0 0", win_seen - wb, obs[24]);
    end
  endtask

  initial begin
    test_reset();
    test_w5();
    test_w8_cont();
    test_w8_random();
    test_bad_size();
    test_abort();
    test_xrst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
